// File: rtl/adc_avg_filter_pkg.sv
// Shared types, width helper and parameter-legality checks for the ADC
// moving-average filter.
package adc_filt_pkg;

   // Control states: waiting for a sample, or running the divider.
   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } state_e;

   localparam int MIN_LOG2_DEPTH = 1;
   localparam int MAX_LOG2_DEPTH = 6;

   // Running-sum width: DEPTH samples of DATA_W bits can never overflow it.
   function automatic int sum_w(input int data_w, input int log2_depth);
      return data_w + log2_depth;
   endfunction

   // True when the window depth and divisor are within their legal ranges.
   function automatic bit cfg_legal(input int data_w, input int log2_depth,
                                    input longint divisor);
      return (log2_depth >= MIN_LOG2_DEPTH) && (log2_depth <= MAX_LOG2_DEPTH) &&
             (divisor >= 1) && (divisor <= ((64'(1) << data_w) - 1));
   endfunction

endpackage

// File: rtl/adc_avg_filter_seq_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, MSB first.
// done is high in the final busy cycle, and quotient carries the finished
// result during that cycle so the caller can register it on the same edge.
module seq_divider
   import adc_filt_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DIVISOR = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);

   localparam int                 CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH:0]     DIV_EXT = (WIDTH + 1)'(DIVISOR);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH:0]   rem_shift;
   logic             q_bit;

   // Next-state: load on start, otherwise one shift/trial-subtract step.
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      q_bit     = 1'b0;
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      if (start && !busy_q) begin
         rem_d  = '0;
         quo_d  = dividend;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         q_bit = (rem_shift >= DIV_EXT);
         rem_d = q_bit ? WIDTH'(rem_shift - DIV_EXT) : WIDTH'(rem_shift);
         quo_d = {quo_q[WIDTH-2:0], q_bit};
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = busy_q && (cnt_q == LAST);
   assign quotient = quo_d;

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average ADC filter: accepts samples over a valid/ready handshake,
// keeps a running window sum, divides (sum >> LOG2_DEPTH) by DIVISOR and
// reports the result with a one-cycle valid pulse.
module adc_avg_filter
   import adc_filt_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int LOG2_DEPTH = 3,
   parameter int DIVISOR    = 65
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_primed,
   output logic              overrun
);

   localparam int                  DEPTH    = 1 << LOG2_DEPTH;
   localparam int                  SUM_W    = sum_w(DATA_W, LOG2_DEPTH);
   localparam int                  CNT_W    = LOG2_DEPTH + 1;
   localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]    DEPTH_M1 = CNT_W'(DEPTH - 1);

   if (!cfg_legal(DATA_W, LOG2_DEPTH, DIVISOR)) begin : g_bad_cfg
      $error("adc_avg_filter: LOG2_DEPTH or DIVISOR out of range");
   end

   state_e                  state_q, state_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic [DATA_W-1:0]       win_q [DEPTH];
   logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    primed_q, primed_d;
   logic                    overrun_q, overrun_d;
   logic                    out_valid_q;
   logic [DATA_W-1:0]       out_data_q, out_data_d;

   logic                    accept;
   logic [SUM_W-1:0]        new_sum;
   logic                    div_busy, div_done;
   logic [DATA_W-1:0]       div_quotient;

   // The oldest sample leaves the window as the new one enters.
   assign new_sum = sum_q + SUM_W'(in_data) - SUM_W'(win_q[wr_ptr_q]);

   // Handshake FSM plus next-state for sum, pointer, fill count and flags.
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      primed_d  = primed_q;
      in_ready  = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_d  = DIV;
               sum_d    = new_sum;
               wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
               if (count_q != DEPTH_C) count_d = count_q + CNT_W'(1);
               if (count_q == DEPTH_M1) primed_d = 1'b1;
            end
         end
         DIV: begin
            if (div_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      overrun_d  = overrun_q | (in_valid & ~in_ready);
      out_data_d = div_done ? div_quotient : out_data_q;
   end

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         primed_q    <= 1'b0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         primed_q    <= primed_d;
         overrun_q   <= overrun_d;
         out_valid_q <= div_done;
         out_data_q  <= out_data_d;
      end
   end

   // Sample window: the slot being overwritten is the one subtracted above.
   // NOTE: the window is cleared on reset because the running sum assumes
   // unfilled slots hold zero; this keeps it in flops rather than RAM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      end else if (accept) begin
         win_q[wr_ptr_q] <= in_data;
      end
   end

   seq_divider #(
      .WIDTH   (DATA_W),
      .DIVISOR (DIVISOR)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept),
      .dividend (new_sum[SUM_W-1:LOG2_DEPTH]),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // The divider runs exactly while the FSM sits in DIV.
   a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == DIV) == div_busy);

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_primed = primed_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter at default parameters
// (DATA_W=16, LOG2_DEPTH=3, DIVISOR=65).
module tb_adc_avg_filter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_primed;
   logic        overrun;

   int n_pass  = 0;
   int n_total = 0;

   adc_avg_filter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_primed (out_primed),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Offer a sample as soon as in_ready is high; returns in cycle T+1.
   task automatic accept_sample(input logic [15:0] d);
      int waited = 0;
      while (!in_ready && waited < 100) begin
         tick();
         waited++;
      end
      check("ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Called in cycle T+1; returns in the out_valid cycle with the latency.
   task automatic wait_result(output logic [15:0] res, output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
      res = out_data;
   endtask

   task automatic send_expect(input string tag, input logic [15:0] d,
                              input logic [15:0] exp);
      logic [15:0] res;
      int          lat;
      accept_sample(d);
      wait_result(res, lat);
      check({tag, "_lat"}, lat, 17);
      check(tag, res, exp);
   endtask

   logic [15:0] res;
   int          lat;
   int          seen;

   initial begin
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_primed", out_primed, 0);
      check("rst_overrun", overrun, 0);

      // 1: single sample after reset, with timing details.
      accept_sample(16'd13000);
      check("c1_busy_ready", in_ready, 0);
      wait_result(res, lat);
      check("c1_lat", lat, 17);
      check("c1_data", res, 25);
      check("c1_ready_at_valid", in_ready, 1);
      check("c1_primed", out_primed, 0);
      tick();
      check("c1_valid_pulse", out_valid, 0);
      repeat (3) tick();
      check("c1_data_hold", out_data, 25);

      // 2: window fill with a constant stream.
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         send_expect($sformatf("c2_r%0d", k), 16'd13000, 16'(25 * k));
         check($sformatf("c2_primed%0d", k), out_primed, (k == 8) ? 1 : 0);
      end

      // 3: window slides out to zero.
      begin
         logic [15:0] exp3 [8] = '{175, 150, 125, 100, 75, 50, 25, 0};
         for (int k = 0; k < 8; k++)
            send_expect($sformatf("c3_z%0d", k + 1), 16'd0, exp3[k]);
      end
      check("c3_primed", out_primed, 1);

      // 4: full-scale input, no sum wrap.
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         accept_sample(16'hFFFF);
         wait_result(res, lat);
         if (k == 4) check("c4_r4", res, 504);
      end
      check("c4_r8", res, 1008);

      // 5: sample offered during DIV is dropped and flagged.
      do_reset();
      accept_sample(16'd13000);          // now in T+1
      repeat (4) tick();                 // now in T+5
      in_valid = 1'b1;
      in_data  = 16'd60000;
      check("c5_ovr_before", overrun, 0);
      tick();                            // now in T+6
      in_valid = 1'b0;
      check("c5_ovr_set", overrun, 1);
      wait_result(res, lat);
      check("c5_lat", lat, 12);          // counted from T+6
      check("c5_r1", res, 25);
      send_expect("c5_r2", 16'd13000, 50);
      check("c5_ovr_sticky", overrun, 1);

      // 6: reset in the middle of a division.
      accept_sample(16'd13000);          // now in T+1
      repeat (7) tick();                 // now in T+8
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("c6_in_ready", in_ready, 1);
      check("c6_out_valid", out_valid, 0);
      check("c6_out_data", out_data, 0);
      check("c6_primed", out_primed, 0);
      check("c6_overrun", overrun, 0);
      seen = 0;
      repeat (30) begin
         if (out_valid) seen++;
         tick();
      end
      check("c6_no_valid", seen, 0);
      send_expect("c6_after", 16'd13000, 25);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

- Parametrised successor to the fixed 8-tap ADC averager.
- Sits between the XADC sample stream and the temperature display path.
- Qualifies samples with a valid/ready handshake and keeps a running-sum moving average of configurable depth.
- Scales the average by an integer divisor using a sequential restoring divider, then reports a registered result with a valid pulse, a window-primed flag and a sticky overrun flag.

## Interface
Parameters:
- DATA_W, 16, sample and result width.
- LOG2_DEPTH, 3, window depth = 2**LOG2_DEPTH samples; legal range 1..6.
- DIVISOR, 65, post-average integer divisor; legal range 1..2**DATA_W-1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  sample present (ADC end-of-conversion).
- in_data  in  DATA_W  unsigned ADC sample.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  one-cycle pulse: new out_data.
- out_data  out  DATA_W  (window sum >> LOG2_DEPTH) / DIVISOR, truncated.
- out_primed  out  1  window holds DEPTH real samples.
- overrun  out  1  sticky: a sample was offered while in_ready=0.

## Operation
- SUM_W = DATA_W + LOG2_DEPTH. The running sum never overflows.
- State machine has two states, IDLE and DIV.
- In IDLE, in_ready=1. When in_valid=1, the sample is accepted:
  - The circular buffer slot at wr_ptr takes the new sample.
  - sum <= sum + in_data − buf[wr_ptr].
  - wr_ptr increments and wraps modulo DEPTH.
  - The fill count increments and saturates at DEPTH.
  - The dividend is loaded with new_sum >> LOG2_DEPTH.
  - State goes to DIV.
- In DIV, in_ready=0. The divider runs one quotient bit per cycle for DATA_W cycles, MSB first, restoring.
- On the last DIV cycle:
  - The quotient is registered into out_data.
  - out_valid is pulsed.
  - State returns to IDLE.
- Warm-up: buffer slots reset to 0. Before the window fills, the sum is still divided by DEPTH, so early results are zero-padded averages.
- out_primed rises on the edge at which count reaches DEPTH. It stays high until reset.
- Overrun: if in_valid=1 while in_ready=0, the sample is dropped, overrun sets, and sum/buffer/pointer are unchanged.
- out_data holds its last value between results.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_primed=0, overrun=0.
  - sum=0, all buffer slots=0, wr_ptr=0, count=0, state=IDLE.
- Reset mid-DIV aborts the division. No out_valid is produced.

## Timing
- Sample accepted in cycle T. Sum and buffer are updated at the edge ending T.
- DIV occupies cycles T+1..T+DATA_W.
- out_valid=1 in cycle T+DATA_W+1. Latency is DATA_W+1 cycles (17 at default).
- in_ready=1 again in cycle T+DATA_W+1. A sample may be accepted in the same cycle as out_valid.
- Minimum sample spacing is DATA_W+1 cycles, far below the 1 µs ADC rate.
- out_valid is never high for two consecutive cycles.
- overrun updates one edge after the offending cycle.

## Structure
- Package adc_filt_pkg holds:
  - the state typedef (IDLE, DIV);
  - a sum_w(DATA_W, LOG2_DEPTH) function;
  - localparam checks on LOG2_DEPTH and DIVISOR.
- Sub-module seq_divider handles the division:
  - Parameters: width and constant divisor.
  - Ports: clk, rst_n, start, dividend, busy, done, quotient.
  - Restoring algorithm, one bit per cycle; done is asserted in the final cycle.
- The top level owns the handshake, buffer, running sum and flags.

## Test plan
Defaults throughout: DATA_W=16, LOG2_DEPTH=3, DIVISOR=65.
1. After reset: one sample of 13000. Result: out_data=25 (sum 13000, avg 1625) exactly 17 cycles after acceptance; out_primed=0.
2. Eight samples of 13000, each offered once in_ready=1. The results of samples 1..8 are 25, 50, 75, 100, 125, 150, 175, 200; out_primed rises with the 8th acceptance.
3. Sliding window: after case 2, four samples of 0. The 4th result is 100 (sum 52000, avg 6500). A further four zeros give 0; out_primed stays 1.
4. Full scale: eight samples of 65535. The 8th result is 1008; the internal sum is 524280 with no wrap.
5. Overrun: in_valid asserted in cycle T+5 during a DIV. The sample is dropped, overrun=1 from T+6 and stays high, and the next result equals that of the undisturbed stream.
6. Reset mid-operation: rst_n=0 for one edge at T+8. No out_valid follows, and all outputs take their reset values. A subsequent single sample of 13000 yields 25.
